// File: rtl/hls_snn_izikevich_hls_deadlock_pkg.sv
// Shared types and constants for the hls_snn_izikevich deadlock reporter.
package hls_snn_izikevich_hls_deadlock_pkg;

  localparam int TS_W              = 32;
  localparam int THRESHOLD_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WATCH,
    ST_REPORT,
    ST_HALT
  } state_e;

endpackage

// File: rtl/hls_snn_izikevich_hls_deadlock_block_counter.sv
// Saturating run-length counter for one monitor `block` input; flags the cycle
// on which the run would reach THRESHOLD.
module hls_snn_izikevich_hls_deadlock_block_counter
  import hls_snn_izikevich_hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = THRESHOLD_DEFAULT,
  parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic block,
  output logic hit,
  output logic is_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (!block)
        cnt_d = '0;
      else if (cnt_q != CNT_W'(THRESHOLD))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign hit     = block && (cnt_q == CNT_W'(THRESHOLD - 1));
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/hls_snn_izikevich_hls_deadlock_reporter.sv
// Filters monitor stalls, latches the first persistent one with a timestamp and
// reports it once over valid/ready; `deadlock` stays set until `clear`.
module hls_snn_izikevich_hls_deadlock_reporter
  import hls_snn_izikevich_hls_deadlock_pkg::*;
#(
  parameter int N_MON     = 4,
  parameter int THRESHOLD = THRESHOLD_DEFAULT,
  parameter int IDX_W     = (N_MON > 1) ? $clog2(N_MON) : 1,
  parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_MON-1:0] mon_block,
  input  logic             clear,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [IDX_W-1:0] report_idx,
  output logic [TS_W-1:0]  report_time,
  output logic             deadlock,
  output logic             any_block
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              deadlock_q, deadlock_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TS_W-1:0]   time_q, time_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              any_block_q, any_block_d;

  logic [N_MON-1:0]  hit;
  logic [N_MON-1:0]  cnt_zero;
  logic              counting;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;

  // Counters run only while detection is armed and freeze once a report is out.
  assign counting = (state_q == ST_IDLE) || (state_q == ST_WATCH);

  for (genvar i = 0; i < N_MON; i++) begin : g_cnt
    hls_snn_izikevich_hls_deadlock_block_counter #(
      .THRESHOLD (THRESHOLD),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .enable  (counting),
      .block   (mon_block[i]),
      .hit     (hit[i]),
      .is_zero (cnt_zero[i])
    );
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    deadlock_d  = deadlock_q;
    idx_d       = idx_q;
    time_d      = time_q;
    ts_d        = ts_q + 1'b1;
    any_block_d = |mon_block;
    if (clear) begin
      state_d    = ST_IDLE;
      valid_d    = 1'b0;
      deadlock_d = 1'b0;
      idx_d      = '0;
      time_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|mon_block)
            state_d = ST_WATCH;
        end
        ST_WATCH: begin
          if (hit_any) begin
            state_d    = ST_REPORT;
            valid_d    = 1'b1;
            deadlock_d = 1'b1;
            idx_d      = hit_idx;
            time_d     = ts_q;
          end else if (&cnt_zero) begin
            state_d = ST_IDLE;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
          end
        end
        ST_HALT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      deadlock_q  <= 1'b0;
      idx_q       <= '0;
      time_q      <= '0;
      ts_q        <= '0;
      any_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      deadlock_q  <= deadlock_d;
      idx_q       <= idx_d;
      time_q      <= time_d;
      ts_q        <= ts_d;
      any_block_q <= any_block_d;
    end
  end

  assign report_valid = valid_q;
  assign deadlock     = deadlock_q;
  assign report_idx   = idx_q;
  assign report_time  = time_q;
  assign any_block    = any_block_q;

endmodule

// File: tb/tb_hls_snn_izikevich_hls_deadlock_reporter.sv
// Bench for the deadlock reporter: directed scenarios plus random blocking,
// checked against a run-length model of the monitor inputs.
module tb_hls_snn_izikevich_hls_deadlock_reporter;

  localparam int N   = 4;
  localparam int THR = 64;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  mon_block;
  logic          clear;
  logic          report_valid;
  logic          report_ready;
  logic [1:0]    report_idx;
  logic [31:0]   report_time;
  logic          deadlock;
  logic          any_block;

  int            vectors;
  int            miscompares;

  // Reference model: consecutive-blocked run lengths and the report bookkeeping.
  int            run_len [N];
  bit            m_valid;
  bit            m_dead;
  int            m_idx;
  logic [31:0]   m_time;
  logic [31:0]   m_ts;
  bit            m_any;

  hls_snn_izikevich_hls_deadlock_reporter #(
    .N_MON     (N),
    .THRESHOLD (THR)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mon_block    (mon_block),
    .clear        (clear),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_idx   (report_idx),
    .report_time  (report_time),
    .deadlock     (deadlock),
    .any_block    (any_block)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic modelReset();
    for (int i = 0; i < N; i++) run_len[i] = 0;
    m_valid = 0;
    m_dead  = 0;
    m_idx   = 0;
    m_time  = '0;
    m_ts    = '0;
    m_any   = 0;
  endtask

  task automatic modelEdge();
    int winner;
    winner = -1;
    if (clear) begin
      for (int i = 0; i < N; i++) run_len[i] = 0;
      m_valid = 0;
      m_dead  = 0;
      m_idx   = 0;
      m_time  = '0;
    end else if (m_valid) begin
      if (report_ready) m_valid = 0;
    end else if (!m_dead) begin
      for (int i = 0; i < N; i++) begin
        if (mon_block[i]) begin
          if (run_len[i] + 1 == THR && winner < 0) winner = i;
          if (run_len[i] < THR) run_len[i] = run_len[i] + 1;
        end else begin
          run_len[i] = 0;
        end
      end
      if (winner >= 0) begin
        m_valid = 1;
        m_dead  = 1;
        m_idx   = winner;
        m_time  = m_ts;
      end
    end
    m_any = |mon_block;
    m_ts  = m_ts + 32'd1;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] exp_idx;
    exp_idx = m_idx[1:0];
    vectors++;
    assert (report_valid === m_valid) else begin
      miscompares++;
      $error("[TB] FAIL %s valid: observed %0b expected %0b", tag, report_valid, m_valid);
    end
    vectors++;
    assert (deadlock === m_dead) else begin
      miscompares++;
      $error("[TB] FAIL %s deadlock: observed %0b expected %0b", tag, deadlock, m_dead);
    end
    vectors++;
    assert (any_block === m_any) else begin
      miscompares++;
      $error("[TB] FAIL %s any_block: observed %0b expected %0b", tag, any_block, m_any);
    end
    vectors++;
    assert (report_idx === exp_idx) else begin
      miscompares++;
      $error("[TB] FAIL %s idx: observed %0d expected %0d", tag, report_idx, exp_idx);
    end
    vectors++;
    assert (report_time === m_time) else begin
      miscompares++;
      $error("[TB] FAIL %s time: observed %h expected %h", tag, report_time, m_time);
    end
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, check at the next fall.
  task automatic applyStimulus(input logic [N-1:0] blk, input logic rdy, input logic clr,
                               input string tag);
    mon_block    = blk;
    report_ready = rdy;
    clear        = clr;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input logic [N-1:0] blk, input logic rdy,
                           input string tag);
    for (int c = 0; c < n; c++) applyStimulus(blk, rdy, 1'b0, tag);
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat;
    logic [N-1:0] blk;
    logic rdy, clr;
    vectors      = 0;
    miscompares  = 0;
    mon_block    = '0;
    report_ready = 1'b0;
    clear        = 1'b0;
    reset_n      = 1'b0;
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput("reset");
    reset_n = 1'b1;

    runCycles(200, 4'b0000, 1'b0, "idle");

    // One cycle short of the threshold must not report.
    runCycles(THR - 1, 4'b0100, 1'b0, "short_stall");
    runCycles(5, 4'b0000, 1'b0, "short_release");
    checkValue("short_no_report", {31'd0, report_valid}, 32'd0);

    // Persistent stall on monitor 1 with the consumer not ready.
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, "stall1");
      if (report_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkValue("stall1_latency", lat, THR);
    checkValue("stall1_idx", {30'd0, report_idx}, 32'd1);
    runCycles(6, 4'b0010, 1'b0, "stall1_hold");
    applyStimulus(4'b0010, 1'b1, 1'b0, "stall1_accept");
    checkValue("stall1_valid_fell", {31'd0, report_valid}, 32'd0);
    runCycles(4, 4'b0010, 1'b0, "stall1_halt");
    checkValue("stall1_sticky", {31'd0, deadlock}, 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, "stall1_clear");
    runCycles(3, 4'b0000, 1'b0, "stall1_idle");

    // Simultaneous hits: lowest index wins, then the survivor re-reports after clear.
    runCycles(THR, 4'b1001, 1'b0, "dual");
    checkValue("dual_idx", {30'd0, report_idx}, 32'd0);
    applyStimulus(4'b1000, 1'b0, 1'b1, "dual_clear");
    runCycles(THR - 1, 4'b1000, 1'b0, "rearm");
    checkValue("rearm_not_yet", {31'd0, report_valid}, 32'd0);
    applyStimulus(4'b1000, 1'b0, 1'b0, "rearm_hit");
    checkValue("rearm_idx", {30'd0, report_idx}, 32'd3);
    applyStimulus(4'b1000, 1'b1, 1'b0, "rearm_accept");
    applyStimulus(4'b0000, 1'b0, 1'b1, "rearm_clear");

    // Clear beats a handshake in the same cycle.
    runCycles(THR, 4'b0100, 1'b0, "clr_vs_rdy");
    applyStimulus(4'b0000, 1'b1, 1'b1, "clr_vs_rdy_edge");
    checkValue("clr_vs_rdy_deadlock", {31'd0, deadlock}, 32'd0);
    runCycles(3, 4'b0000, 1'b0, "clr_vs_rdy_after");

    // Asynchronous reset in the middle of a report.
    runCycles(THR, 4'b0001, 1'b0, "async");
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    #1 reset_n = 1'b1;
    mon_block = '0;
    @(negedge clock);

    // Timestamp near wrap: the report time must show the wrapped count.
    force dut.ts_q = 32'hFFFF_FFF0;
    #1 release dut.ts_q;
    m_ts = 32'hFFFF_FFF0;
    runCycles(THR, 4'b0001, 1'b0, "wrap");
    checkValue("wrap_time", report_time, 32'h0000_002F);
    applyStimulus(4'b0000, 1'b0, 1'b1, "wrap_clear");

    // Random blocking, handshakes and clears.
    blk = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (blk[i]) begin
          if ($urandom_range(0, 99) == 0) blk[i] = 1'b0;
        end else if ($urandom_range(0, 29) == 0) begin
          blk[i] = 1'b1;
        end
      end
      rdy = ($urandom_range(0, 7) == 0);
      clr = (m_dead && $urandom_range(0, 59) == 0) || ($urandom_range(0, 499) == 0);
      applyStimulus(blk, rdy, clr, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
